// File: rtl/sprite_blit_pkg.sv
// Shared state encoding and default geometry for the sprite blitter.
// The default geometry describes a 120x96 sprite sheet and a 640x480 frame buffer.
package sprite_blit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  localparam int SHEET_W_DEF   = 120;
  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 5;
  localparam int TILE_W_DEF    = 24;
  localparam int TILE_H_DEF    = 24;
  localparam int FB_W_DEF      = 640;
  localparam int FB_H_DEF      = 480;
  localparam int FB_ADDR_W_DEF = 19;
  localparam int DST_X_W       = 10;
  localparam int DST_Y_W       = 9;

  localparam logic [4:0] TRANSPARENT_DEF = 5'h00;

endpackage

// File: rtl/blit_addr_gen.sv
// Tile walk for the sprite blitter. Counters and addresses describe the texel
// being issued this cycle, and rom_addr always equals row_base + tx.
module blit_addr_gen
  import sprite_blit_pkg::*;
#(
  parameter int SHEET_W   = SHEET_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int TILE_W    = TILE_W_DEF,
  parameter int TILE_H    = TILE_H_DEF,
  parameter int FB_W      = FB_W_DEF,
  parameter int FB_ADDR_W = FB_ADDR_W_DEF,
  parameter int TX_W      = $clog2(TILE_W),
  parameter int TY_W      = $clog2(TILE_H)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [DST_X_W-1:0]   dst_x,
  input  logic [DST_Y_W-1:0]   dst_y,
  output logic [TX_W-1:0]      tx,
  output logic [TY_W-1:0]      ty,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [FB_ADDR_W-1:0] fb_row_base,
  output logic [DST_X_W-1:0]   dst_x_q,
  output logic [DST_Y_W-1:0]   dst_y_q,
  output logic                 last
);

  logic [ADDR_W-1:0] row_base;
  logic              row_end;

  assign row_end = (tx == TX_W'(TILE_W - 1));
  assign last    = row_end && (ty == TY_W'(TILE_H - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx          <= '0;
      ty          <= '0;
      row_base    <= '0;
      rom_addr    <= '0;
      fb_row_base <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
    end else if (load) begin
      tx          <= '0;
      ty          <= '0;
      row_base    <= src_base;
      rom_addr    <= src_base;
      // The only multiply in the blitter: the first destination row offset.
      fb_row_base <= FB_ADDR_W'(dst_y) * FB_ADDR_W'(FB_W);
      dst_x_q     <= dst_x;
      dst_y_q     <= dst_y;
    end else if (advance) begin
      if (row_end) begin
        tx          <= '0;
        ty          <= ty + 1'b1;
        row_base    <= row_base + ADDR_W'(SHEET_W);
        rom_addr    <= row_base + ADDR_W'(SHEET_W);
        fb_row_base <= fb_row_base + FB_ADDR_W'(FB_W);
      end else begin
        tx       <= tx + 1'b1;
        rom_addr <= rom_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one tile from the sprite-sheet ROM into the frame buffer, skipping
// transparent and off-screen texels. A texel issued in cycle n is written in cycle n+2.
module sprite_blitter
  import sprite_blit_pkg::*;
#(
  parameter int SHEET_W   = SHEET_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TILE_W    = TILE_W_DEF,
  parameter int TILE_H    = TILE_H_DEF,
  parameter int FB_W      = FB_W_DEF,
  parameter int FB_H      = FB_H_DEF,
  parameter int FB_ADDR_W = FB_ADDR_W_DEF,
  parameter logic [DATA_W-1:0] TRANSPARENT = DATA_W'(TRANSPARENT_DEF)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [DST_X_W-1:0]   dst_x,
  input  logic [DST_Y_W-1:0]   dst_y,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_W-1:0]    rom_data,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0]    fb_data
);

  localparam int TX_W = $clog2(TILE_W);
  localparam int TY_W = $clog2(TILE_H);
  localparam int XS_W = DST_X_W + 1;
  localparam int YS_W = DST_Y_W + 1;

  function automatic logic on_screen(input logic [XS_W-1:0] xs, input logic [YS_W-1:0] ys);
    return (xs < XS_W'(FB_W)) && (ys < YS_W'(FB_H));
  endfunction

  blit_state_t state, state_nxt;
  logic        drain_cnt;
  logic        load, advance, last;

  logic [TX_W-1:0]      tx;
  logic [TY_W-1:0]      ty;
  logic [FB_ADDR_W-1:0] fb_row_base;
  logic [DST_X_W-1:0]   dst_x_q;
  logic [DST_Y_W-1:0]   dst_y_q;

  blit_addr_gen #(
    .SHEET_W  (SHEET_W),
    .ADDR_W   (ADDR_W),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H),
    .FB_W     (FB_W),
    .FB_ADDR_W(FB_ADDR_W)
  ) u_addr_gen (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .load       (load),
    .advance    (advance),
    .src_base   (src_base),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
    .tx         (tx),
    .ty         (ty),
    .rom_addr   (rom_addr),
    .fb_row_base(fb_row_base),
    .dst_x_q    (dst_x_q),
    .dst_y_q    (dst_y_q),
    .last       (last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        advance = 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: texel issued this cycle, rom_addr presented to the ROM
  logic                 vld_p0;
  logic [XS_W-1:0]      x_sum_p0;
  logic [YS_W-1:0]      y_sum_p0;
  logic [FB_ADDR_W-1:0] fb_addr_p0;

  assign vld_p0     = advance;
  assign x_sum_p0   = {1'b0, dst_x_q} + XS_W'(tx);
  assign y_sum_p0   = {1'b0, dst_y_q} + YS_W'(ty);
  assign fb_addr_p0 = fb_row_base + FB_ADDR_W'(dst_x_q) + FB_ADDR_W'(tx);

  // Stage p1: aligned with rom_data returned by the ROM
  logic                 vld_p1;
  logic                 keep_p1;
  logic [FB_ADDR_W-1:0] fb_addr_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= vld_p0;
  end

  always_ff @(posedge Clk) begin
    keep_p1    <= on_screen(x_sum_p0, y_sum_p0);
    fb_addr_p1 <= fb_addr_p0;
  end

  // Stage p2: registered frame-buffer write port
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= vld_p1 && keep_p1 && (rom_data != TRANSPARENT);
      if (vld_p1) begin
        fb_addr <= fb_addr_p1;
        fb_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: registered ROM model plus a frame-buffer
// capture array, with hand-computed write counts, addresses and timings.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] src_base = '0;
  logic [9:0]  dst_x = '0;
  logic [8:0]  dst_y = '0;
  logic        busy, done, fb_we;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;

  sprite_blitter dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .src_base(src_base),
    .dst_x   (dst_x),
    .dst_y   (dst_y),
    .busy    (busy),
    .done    (done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_data (fb_data)
  );

  always #5 Clk = ~Clk;

  logic [4:0] rom [0:11519];
  logic [5:0] fb_mem [0:307199];

  always @(posedge Clk) rom_data <= (rom_addr < 14'd11520) ? rom[rom_addr] : 5'd0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0, t0 = 0, rel = 0;
  int wr_cnt, oob_cnt, done_cnt, done_c, done_first, first_we_c;
  logic [18:0] first_we_addr, max_addr;
  logic        busy_c1;
  logic [13:0] rom_addr_25;

  task automatic tick();
    @(negedge Clk);
    cyc++;
    rel = cyc - t0;
    if (fb_we) begin
      wr_cnt++;
      if (first_we_c < 0) begin
        first_we_c    = rel;
        first_we_addr = fb_addr;
      end
      if (fb_addr > max_addr) max_addr = fb_addr;
      if (fb_addr < 19'd307200) fb_mem[fb_addr] = {1'b1, fb_data};
      else oob_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_c = rel;
      if (done_cnt == 1) done_first = rel;
    end
    if (rel == 1) busy_c1 = busy;
    if (rel == 25) rom_addr_25 = rom_addr;
  endtask

  task automatic clear_counts();
    wr_cnt = 0; oob_cnt = 0; done_cnt = 0; done_c = -1; done_first = -1;
    first_we_c = -1; first_we_addr = '0; max_addr = '0; busy_c1 = 1'b0; rom_addr_25 = '0;
  endtask

  task automatic clear_fb();
    for (int i = 0; i < 307200; i++) fb_mem[i] = 6'd0;
  endtask

  task automatic begin_blit(input logic [13:0] sb, input logic [9:0] dx, input logic [8:0] dy);
    src_base = sb; dst_x = dx; dst_y = dy;
    start = 1'b1;
    t0 = cyc;
    clear_counts();
    tick();
    start = 1'b0;
  endtask

  task automatic run_to(input int r);
    while (rel < r) tick();
  endtask

  task automatic test_reset();
    int bad;
    Reset_n = 1'b0;
    clear_counts();
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    n_vec++; if (fb_addr !== 19'd0) begin n_bad++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    n_vec++; if (fb_data !== 5'd0) begin n_bad++; $display("FAIL reset_fb_data: got %0d want 0", fb_data); end
    n_vec++; if (rom_addr !== 14'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    bad = 0;
    repeat (10) begin
      tick();
      if (rom_addr !== 14'd0 || fb_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_opaque();
    int bad;
    clear_fb();
    begin_blit(14'd0, 10'd0, 9'd0);
    run_to(590);
    n_vec++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL opaque_busy_c1: got %b want 1", busy_c1); end
    n_vec++; if (wr_cnt !== 576) begin n_bad++; $display("FAIL opaque_writes: got %0d want 576", wr_cnt); end
    n_vec++; if (first_we_c !== 3) begin n_bad++; $display("FAIL opaque_first_cycle: got %0d want 3", first_we_c); end
    n_vec++; if (first_we_addr !== 19'd0) begin n_bad++; $display("FAIL opaque_first_addr: got %0d want 0", first_we_addr); end
    n_vec++; if (fb_mem[14743] !== {1'b1, 5'd25}) begin n_bad++; $display("FAIL opaque_px_23_23: got %0h want 39", fb_mem[14743]); end
    n_vec++; if (done_c !== 579) begin n_bad++; $display("FAIL opaque_done_cycle: got %0d want 579", done_c); end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL opaque_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL opaque_busy_after: got %b want 0", busy); end
    bad = 0;
    for (int ty = 0; ty < 24; ty++)
      for (int tx = 0; tx < 24; tx++)
        if (fb_mem[ty*640 + tx] !== {1'b1, rom[ty*120 + tx]}) bad++;
    n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL opaque_image: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_transparent();
    int bad;
    clear_fb();
    begin_blit(14'd24, 10'd100, 9'd50);
    run_to(590);
    n_vec++; if (rom_addr_25 !== 14'd144) begin n_bad++; $display("FAIL transp_row1_addr: got %0d want 144", rom_addr_25); end
    n_vec++; if (wr_cnt !== 575) begin n_bad++; $display("FAIL transp_writes: got %0d want 575", wr_cnt); end
    n_vec++; if (fb_mem[34025][5] !== 1'b0) begin n_bad++; $display("FAIL transp_skip_105_53: got %0h want unwritten", fb_mem[34025]); end
    bad = 0;
    for (int ty = 0; ty < 24; ty++)
      for (int tx = 0; tx < 24; tx++)
        if (!(ty == 3 && tx == 5) && fb_mem[(50+ty)*640 + 100 + tx] !== {1'b1, rom[24 + ty*120 + tx]}) bad++;
    n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL transp_image: got %0d bad pixels want 0", bad); end
    n_vec++; if (done_c !== 579) begin n_bad++; $display("FAIL transp_done_cycle: got %0d want 579", done_c); end
  endtask

  task automatic test_clip();
    int bad;
    clear_fb();
    begin_blit(14'd0, 10'd630, 9'd470);
    run_to(590);
    n_vec++; if (wr_cnt !== 100) begin n_bad++; $display("FAIL clip_writes: got %0d want 100", wr_cnt); end
    n_vec++; if (oob_cnt !== 0) begin n_bad++; $display("FAIL clip_oob: got %0d want 0", oob_cnt); end
    n_vec++; if (max_addr > 19'd307199) begin n_bad++; $display("FAIL clip_max_addr: got %0d want <=307199", max_addr); end
    n_vec++; if (done_c !== 579) begin n_bad++; $display("FAIL clip_done_cycle: got %0d want 579", done_c); end
    bad = 0;
    for (int ty = 0; ty < 10; ty++)
      for (int tx = 0; tx < 10; tx++)
        if (fb_mem[(470+ty)*640 + 630 + tx] !== {1'b1, rom[ty*120 + tx]}) bad++;
    n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL clip_image: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_restart_ignored();
    int bad;
    clear_fb();
    begin_blit(14'd0, 10'd0, 9'd0);
    while (rel < 600) begin
      tick();
      if (rel == 99) begin start = 1'b1; src_base = 14'd100; dst_x = 10'd300; end
      if (rel == 100) start = 1'b0;
    end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (done_c !== 579) begin n_bad++; $display("FAIL restart_done_cycle: got %0d want 579", done_c); end
    n_vec++; if (wr_cnt !== 576) begin n_bad++; $display("FAIL restart_writes: got %0d want 576", wr_cnt); end
    n_vec++; if (fb_mem[300][5] !== 1'b0) begin n_bad++; $display("FAIL restart_no_redirect: got %0h want unwritten", fb_mem[300]); end
    bad = 0;
    for (int ty = 0; ty < 24; ty++)
      for (int tx = 0; tx < 24; tx++)
        if (fb_mem[ty*640 + tx] !== {1'b1, rom[ty*120 + tx]}) bad++;
    n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL restart_image: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_reset_mid();
    clear_fb();
    begin_blit(14'd0, 10'd0, 9'd0);
    run_to(200);
    Reset_n = 1'b0;
    #1;
    n_vec++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL midrst_fb_we: got %b want 0", fb_we); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (rom_addr !== 14'd0) begin n_bad++; $display("FAIL midrst_rom_addr: got %0d want 0", rom_addr); end
    repeat (2) tick();
    Reset_n = 1'b1;
    clear_counts();
    t0 = cyc;
    run_to(600);
    n_vec++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL midrst_writes_after: got %0d want 0", wr_cnt); end
    n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    begin_blit(14'd0, 10'd0, 9'd0);
    run_to(590);
    n_vec++; if (done_c !== 579) begin n_bad++; $display("FAIL midrst_new_done: got %0d want 579", done_c); end
    n_vec++; if (wr_cnt !== 576) begin n_bad++; $display("FAIL midrst_new_writes: got %0d want 576", wr_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_fb();
    begin_blit(14'd0, 10'd0, 9'd0);
    start = 1'b1;
    while (rel < 1200) begin
      tick();
      if (rel == 600) start = 1'b0;
    end
    n_vec++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_vec++; if (done_first !== 579) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 579", done_first); end
    n_vec++; if (done_c !== 1159) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 1159", done_c); end
    n_vec++; if (wr_cnt !== 1152) begin n_bad++; $display("FAIL b2b_writes: got %0d want 1152", wr_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 11520; i++) rom[i] = 5'((i % 31) + 1);
    rom[389] = 5'd0;
    test_reset();
    test_opaque();
    test_transparent();
    test_clip();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
